gpio_edge_periph: RTL
=====================

# gpio_edge_periph

APB responder peripheral providing one bidirectional GPIO port with per-pin direction control, a synchronized input data register and rising/falling edge capture with a level interrupt. It attaches to one APB_Master select line (PSEL3/PSEL4 slot) inside MCU, alongside fnd_Periph, timer_Periph and uart_Periph, and answers the CPU's load/store traffic with one wait state.

## Interface
- WIDTH, 8, number of GPIO pins (1..32)
- PCLK  in  1  APB clock; sole clock
- PRESET  in  1  reset; synchronous, active-high
- PADDR  in  32  byte address; only PADDR[4:2] decoded
- PWDATA  in  32  write data; bits [WIDTH-1:0] used
- PWRITE  in  1  1 = write, 0 = read
- PENABLE  in  1  APB access phase
- PSEL  in  1  select from APB_Master
- PRDATA  out  32  read data, zero-extended
- PREADY  out  1  transfer complete
- irq  out  1  level interrupt, OR of edge status bits
- inoutPort  inout  WIDTH  GPIO pins

## Operation
- Register map (word offsets): 0x00 MODER (RW, 1 = output), 0x04 ODR (RW), 0x08 IDR (RO, synchronized pins), 0x0C RISE_EN (RW), 0x10 FALL_EN (RW), 0x14 EDGE_STAT (read; write-1-to-clear). 0x18/0x1C: read 0, writes ignored, still complete normally.
- Pin drive: inoutPort[i] = MODER[i] ? ODR[i] : 'z. IDR reads back all pins, including outputs.
- Input path per pin: s1 <= pin, s2 <= s1, s3 <= s2. IDR = s2. rise = s2 & ~s3 & RISE_EN; fall = ~s2 & s3 & FALL_EN.
- EDGE_STAT[i] <= (EDGE_STAT[i] & ~clr[i]) | rise[i] | fall[i]; clr = PWDATA on committed write to 0x14. Simultaneous event and clear: event wins, bit stays 1.
- irq = |EDGE_STAT (combinational from register).
- Writes to IDR ignored. Bits above WIDTH read 0.
- Handshake FSM: IDLE -> SETUP when PSEL & ~PENABLE; SETUP -> WAIT when PSEL & PENABLE; WAIT -> IDLE, asserting PREADY for that one cycle. PSEL dropping in SETUP/WAIT returns to IDLE with no commit.
- Write commits on the PCLK edge ending the PREADY=1 cycle. PRDATA valid only while PREADY=1, 0 otherwise.

## Timing
- Reset (PRESET high at a PCLK edge): MODER, ODR, RISE_EN, FALL_EN, EDGE_STAT, s1..s3 = 0; FSM IDLE; PREADY = 0; PRDATA = 0; irq = 0; all pins high-Z. Reset mid-transfer aborts it; no register commit.
- Transfer: setup cycle T0, access T1 (PREADY=0, wait), T2 (PREADY=1). Back-to-back transfers: next setup may start at T3.
- Pin change sampled at edge N: IDR reflects it after edge N+1; EDGE_STAT and irq after edge N+2.
- Pulse shorter than one PCLK period may be missed; edges separated by one cycle each set status.
- ODR/MODER write visible on pins after the commit edge.

## Configuration
- GPIO_EDGE_IRQ_EN defined: edge logic, RISE_EN/FALL_EN/EDGE_STAT and irq as above.
- Undefined: offsets 0x0C-0x14 read 0 and ignore writes; s3 and edge logic absent; irq tied 0. Handshake, MODER/ODR/IDR unchanged.

## Structure
- Package gpio_pkg: register offset localparams (MODER_OFS ... EDGE_STAT_OFS), handshake FSM state enum (IDLE, SETUP, WAIT).
- Sub-module gpio_edge_detect: synchronizer, edge detect, EDGE_STAT with W1C, irq; instantiated once, parameterized by WIDTH. Top holds APB FSM, register file, read mux and tri-state drivers.

## Test plan
- Reset mid-write to ODR (PRESET during WAIT) -> no commit; ODR=0, PREADY=0, pins high-Z.
- Write MODER=0x0F, ODR=0xA5 -> pins[3:0]=4'b0101, [7:4]=Z; read IDR with pins[7:4] driven 4'b1100 -> PRDATA=0x000000C5 two cycles later; PREADY high exactly on third cycle of each transfer.
- RISE_EN=0x01, pin0 0->1 at edge N -> EDGE_STAT=0x01 and irq=1 after edge N+2; FALL_EN=0 so 1->0 sets nothing.
- EDGE_STAT=0x03, write 0x01 to 0x14 -> reads 0x02, irq stays 1; write 0x02 in same cycle pin1 edge fires -> bit1 remains 1.
- Read 0x1C -> PRDATA=0, PREADY asserted normally; write 0x08 -> IDR unaffected.
- Build without GPIO_EDGE_IRQ_EN: toggle pins with RISE_EN write 0xFF -> read 0x0C returns 0, irq stays 0.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared register offsets and APB handshake states for the GPIO edge peripheral.
// Word offsets are the PADDR[4:2] field.
package gpio_pkg;

  localparam logic [2:0] MODER_OFS     = 3'd0;
  localparam logic [2:0] ODR_OFS       = 3'd1;
  localparam logic [2:0] IDR_OFS       = 3'd2;
  localparam logic [2:0] RISE_EN_OFS   = 3'd3;
  localparam logic [2:0] FALL_EN_OFS   = 3'd4;
  localparam logic [2:0] EDGE_STAT_OFS = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WAIT  = 2'd2
  } apb_state_e;

endpackage

// File: rtl/gpio_edge_periph_if.sv
// APB bus bundle between APB_Master and the GPIO peripheral.
interface gpio_edge_periph_if;

  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PENABLE;
  logic        PSEL;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (
    output PADDR, PWDATA, PWRITE, PENABLE, PSEL,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PENABLE, PSEL,
    output PRDATA, PREADY
  );

endinterface

// File: rtl/gpio_edge_detect.sv
// Pin synchronizer plus optional rise/fall capture with write-1-to-clear status.
// Edge logic present only when GPIO_EDGE_IRQ_EN is defined.
module gpio_edge_detect #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] idr
`ifdef GPIO_EDGE_IRQ_EN
  ,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] edge_stat,
  output logic             irq
`endif
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pins;
      s2 <= s1;
    end
  end

  assign idr = s2;

`ifdef GPIO_EDGE_IRQ_EN
  logic [WIDTH-1:0] s3;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  assign rise = s2 & ~s3 & rise_en;
  assign fall = ~s2 & s3 & fall_en;

  // A new event in the same cycle as its clear keeps the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3        <= '0;
      edge_stat <= '0;
    end else begin
      s3        <= s2;
      edge_stat <= (edge_stat & ~clr) | rise | fall;
    end
  end

  assign irq = |edge_stat;
`endif

endmodule

// File: rtl/gpio_edge_periph.sv
// APB GPIO peripheral: handshake FSM, register file, read mux and pin drivers.
// Edge capture registers and irq exist only when GPIO_EDGE_IRQ_EN is defined.
//
//   state | meaning
//   IDLE  | no transfer; waiting for PSEL with PENABLE low
//   SETUP | setup phase seen; waiting for PENABLE
//   WAIT  | PREADY high this cycle; write commits on the closing edge
module gpio_edge_periph
  import gpio_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               PCLK,
  input  logic               PRESET,
  gpio_edge_periph_if.slave  bus,
  output logic               irq,
  inout  wire  [WIDTH-1:0]   inoutPort
);

  apb_state_e state;
  apb_state_e state_nxt;

  logic             pready;
  logic             commit_wr;
  logic [2:0]       reg_sel;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] moder;
  logic [WIDTH-1:0] odr;
  logic [WIDTH-1:0] idr;
  logic [WIDTH-1:0] rdata_w;
  logic [31:0]      rdata;
  logic             unused_bits;

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.PSEL && !bus.PENABLE) state_nxt = SETUP;
      SETUP: begin
        if (!bus.PSEL)        state_nxt = IDLE;
        else if (bus.PENABLE) state_nxt = WAIT;
      end
      WAIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A master that drops PSEL in WAIT gets no PREADY and no commit.
  assign pready    = (state == WAIT) && bus.PSEL;
  assign commit_wr = pready && bus.PWRITE;
  assign reg_sel   = bus.PADDR[4:2];
  assign wdata     = bus.PWDATA[WIDTH-1:0];

  assign bus.PREADY = pready;
  assign bus.PRDATA = pready ? rdata : 32'd0;

  assign unused_bits = ^{bus.PADDR[31:5], bus.PADDR[1:0], bus.PWDATA};

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      moder <= '0;
      odr   <= '0;
    end else if (commit_wr) begin
      case (reg_sel)
        MODER_OFS: moder <= wdata;
        ODR_OFS:   odr   <= wdata;
        default:   ;
      endcase
    end
  end

`ifdef GPIO_EDGE_IRQ_EN
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] edge_stat;
  logic [WIDTH-1:0] clr;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rise_en <= '0;
      fall_en <= '0;
    end else if (commit_wr) begin
      case (reg_sel)
        RISE_EN_OFS: rise_en <= wdata;
        FALL_EN_OFS: fall_en <= wdata;
        default:     ;
      endcase
    end
  end

  assign clr = (commit_wr && reg_sel == EDGE_STAT_OFS) ? wdata : '0;

  gpio_edge_detect #(.WIDTH(WIDTH)) u_edge (
    .clk       (PCLK),
    .rst       (PRESET),
    .pins      (inoutPort),
    .idr       (idr),
    .rise_en   (rise_en),
    .fall_en   (fall_en),
    .clr       (clr),
    .edge_stat (edge_stat),
    .irq       (irq)
  );
`else
  gpio_edge_detect #(.WIDTH(WIDTH)) u_edge (
    .clk  (PCLK),
    .rst  (PRESET),
    .pins (inoutPort),
    .idr  (idr)
  );

  assign irq = 1'b0;
`endif

  always_comb begin
    rdata_w = '0;
    case (reg_sel)
      MODER_OFS:     rdata_w = moder;
      ODR_OFS:       rdata_w = odr;
      IDR_OFS:       rdata_w = idr;
`ifdef GPIO_EDGE_IRQ_EN
      RISE_EN_OFS:   rdata_w = rise_en;
      FALL_EN_OFS:   rdata_w = fall_en;
      EDGE_STAT_OFS: rdata_w = edge_stat;
`endif
      default:       rdata_w = '0;
    endcase
  end

  always_comb begin
    rdata = '0;
    rdata[WIDTH-1:0] = rdata_w;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign inoutPort[i] = moder[i] ? odr[i] : 1'bz;
  end

endmodule
